// File: rtl/exec_pkg.sv
// Shared execute-stage types and constants: condition-code layout, ifun encodings, reset values.
package exec_pkg;

   localparam int DEF_WIDTH = 64;

   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } cc_t;

   localparam cc_t CC_RESET = 3'b100;

   localparam logic [3:0] C_ALWAYS = 4'd0;
   localparam logic [3:0] C_LE     = 4'd1;
   localparam logic [3:0] C_L      = 4'd2;
   localparam logic [3:0] C_E      = 4'd3;
   localparam logic [3:0] C_NE     = 4'd4;
   localparam logic [3:0] C_GE     = 4'd5;
   localparam logic [3:0] C_G      = 4'd6;

endpackage

// File: rtl/exec_cond_eval.sv
// Combinational jXX/cmovXX condition evaluation from a condition-code value.
module exec_cond_eval
   import exec_pkg::*;
(
   input  cc_t        cc,
   input  logic [3:0] ifun,
   output logic       cnd
);

   logic lt;

   assign lt = cc.sf ^ cc.of;

   always_comb begin
      cnd = 1'b0;
      case (ifun)
         C_ALWAYS: cnd = 1'b1;
         C_LE:     cnd = lt | cc.zf;
         C_L:      cnd = lt;
         C_E:      cnd = cc.zf;
         C_NE:     cnd = !cc.zf;
         C_GE:     cnd = !lt;
         C_G:      cnd = !lt & !cc.zf;
         default:  cnd = 1'b0;
      endcase
   end

endmodule

// File: rtl/exec_cc_stage.sv
// Execute back end: CC register, condition evaluation and a 2-entry skid buffer toward memory/writeback.
// Optional stall counter enabled by defining EXEC_CC_PERF_EN.
module exec_cc_stage
   import exec_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int PERF_W = 32
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_result,
   input  logic              in_overflow,
   input  logic              in_set_cc,
   input  logic [3:0]        in_ifun,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_result,
   output logic              out_cnd,
   output logic [2:0]        out_cc,
   output logic [PERF_W-1:0] perf_stall_cnt
);

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             cnd;
      cc_t              cc;
   } entry_t;

   cc_t    cc_reg;
   cc_t    cc_new;
   cc_t    cc_after;
   entry_t m_reg;
   entry_t s_reg;
   entry_t in_entry;
   logic   m_valid_reg;
   logic   s_valid_reg;
   logic   accept;
   logic   xfer;
   logic   cnd;

   // in_ready comes straight from the skid-valid flop, so it is registered
   assign in_ready = !s_valid_reg;
   assign accept   = in_valid & in_ready;
   assign xfer     = m_valid_reg & out_ready;

   always_comb begin
      cc_new.zf = (in_result == '0);
      cc_new.sf = in_result[WIDTH-1];
      cc_new.of = in_overflow;
   end

   assign cc_after = in_set_cc ? cc_new : cc_reg;

   // Condition sees the CC before this transaction's own update
   exec_cond_eval u_cond (
      .cc   (cc_reg),
      .ifun (in_ifun),
      .cnd  (cnd)
   );

   always_comb begin
      in_entry.result = in_result;
      in_entry.cnd    = cnd;
      in_entry.cc     = cc_after;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc_reg      <= CC_RESET;
         m_valid_reg <= 1'b0;
         s_valid_reg <= 1'b0;
         m_reg       <= '{result: '0, cnd: 1'b0, cc: CC_RESET};
         s_reg       <= '{result: '0, cnd: 1'b0, cc: CC_RESET};
      end else if (flush) begin
         m_valid_reg <= 1'b0;
         s_valid_reg <= 1'b0;
      end else begin
         if (accept && in_set_cc) begin
            cc_reg <= cc_new;
         end
         if (!m_valid_reg || xfer) begin
            if (s_valid_reg) begin
               m_reg       <= s_reg;
               m_valid_reg <= 1'b1;
               s_valid_reg <= 1'b0;
            end else begin
               m_valid_reg <= accept;
               if (accept) begin
                  m_reg <= in_entry;
               end
            end
         end else if (accept) begin
            s_reg       <= in_entry;
            s_valid_reg <= 1'b1;
         end
      end
   end

   assign out_valid  = m_valid_reg;
   assign out_result = m_reg.result;
   assign out_cnd    = m_reg.cnd;
   assign out_cc     = m_reg.cc;

`ifdef EXEC_CC_PERF_EN
   logic [PERF_W-1:0] perf_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_reg <= '0;
      end else if (m_valid_reg && !out_ready && (perf_reg != '1)) begin
         perf_reg <= perf_reg + 1'b1;
      end
   end

   assign perf_stall_cnt = perf_reg;
`else
   assign perf_stall_cnt = '0;
`endif

endmodule
